// File: rtl/vga_ctrl_pkg.sv
// Shared VGA timing constants and the types used by the frame-sync scheduler.
package vga_ctrl_pkg;

  // 640x480 @ 60 Hz horizontal timing, in pixel clocks
  localparam int H_PIXEL = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOTAL = H_PIXEL + H_FRONT + H_SYNC + H_BACK;

  // 640x480 @ 60 Hz vertical timing, in lines
  localparam int V_PIXEL = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOTAL = V_PIXEL + V_FRONT + V_SYNC + V_BACK;

  // Frame scheduler phases: visible region, the single commit cycle, vertical blank
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    COMMIT = 2'd1,
    BLANK  = 2'd2
  } fs_state_t;

  // Requester identities, also used as the round-robin pointer value
  typedef enum logic {
    ELEV = 1'b0,
    PPL  = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is the elevator requester, bit 1 the
// people requester. The pointer only moves when both ask in the same cycle,
// so a lone requester never disturbs fairness for the next collision.
module rr_arbiter2
  import vga_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_t ptr_q;
  req_id_t ptr_d;

  // Pick a winner and decide whether the pointer flips this cycle
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (enable) begin
      unique case (req)
        2'b01: grant = 2'b01;
        2'b10: grant = 2'b10;
        2'b11: begin
          grant = (ptr_q == ELEV) ? 2'b01 : 2'b10;
          ptr_d = (ptr_q == ELEV) ? PPL : ELEV;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer register, starts favouring the elevator
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= ELEV;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vga_frame_sync.sv
// Display-update scheduler. Elevator and people updates land in shadow
// registers at any time; they are copied to the display-visible registers
// only at vertical-blank entry so the pixel generator never sees a torn frame.
module vga_frame_sync
  import vga_ctrl_pkg::*;
#(
  parameter int COMMIT_EVERY = 1,
  parameter int FCNT_W       = 8
) (
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic [9:0]        horiz_count,
  input  logic [9:0]        vert_count,
  input  logic              elev_req,
  input  logic [7:0]        elev_destination,
  input  logic [1:0]        elev_sim_state,
  output logic              elev_ack,
  input  logic              ppl_req,
  input  logic [25:0]       ppl_data,
  output logic              ppl_ack,
  output logic [7:0]        destination,
  output logic [1:0]        sim_state,
  output logic [25:0]       people_data,
  output logic              commit,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count,
  output logic              pending
);

  localparam logic [3:0] DIV_LAST = 4'(COMMIT_EVERY - 1);

  fs_state_t         state_q, state_d;
  logic [3:0]        div_q, div_d;
  logic [7:0]        sh_dest_q, sh_dest_d;
  logic [1:0]        sh_sim_q, sh_sim_d;
  logic [25:0]       sh_ppl_q, sh_ppl_d;
  logic [1:0]        dirty_q, dirty_d;
  logic [7:0]        dest_q, dest_d;
  logic [1:0]        sim_q, sim_d;
  logic [25:0]       people_q, people_d;
  logic              commit_q, commit_d;
  logic              elev_ack_q, elev_ack_d;
  logic              ppl_ack_q, ppl_ack_d;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;

  logic       in_range;
  logic       at_vblank;
  logic       at_top;
  logic [1:0] arb_req;
  logic [1:0] grant;

  // A request still high during its own ack cycle is the old request, not a new one
  assign arb_req   = {ppl_req & ~ppl_ack_q, elev_req & ~elev_ack_q};
  assign in_range  = (horiz_count < 10'(H_TOTAL)) && (vert_count < 10'(V_TOTAL));
  assign at_vblank = in_range && (vert_count == 10'(V_PIXEL)) && (horiz_count == 10'd0);
  assign at_top    = in_range && (vert_count == 10'd0) && (horiz_count == 10'd0);

  rr_arbiter2 u_arb (
    .clk     (pixel_clk),
    .reset_n (reset_n),
    .enable  (state_q != COMMIT),
    .req     (arb_req),
    .grant   (grant)
  );

  // Shadow writes, commit/throttle decision and frame-phase transitions
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    sh_dest_d     = sh_dest_q;
    sh_sim_d      = sh_sim_q;
    sh_ppl_d      = sh_ppl_q;
    dirty_d       = dirty_q;
    dest_d        = dest_q;
    sim_d         = sim_q;
    people_d      = people_q;
    commit_d      = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    elev_ack_d    = grant[0];
    ppl_ack_d     = grant[1];

    if (grant[0]) begin
      sh_dest_d  = elev_destination;
      sh_sim_d   = elev_sim_state;
      dirty_d[0] = 1'b1;
    end
    if (grant[1]) begin
      sh_ppl_d   = ppl_data;
      dirty_d[1] = 1'b1;
    end

    case (state_q)
      ACTIVE: begin
        if (at_vblank) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = BLANK;
        if (div_q == DIV_LAST) begin
          div_d = 4'd0;
          if (dirty_q[0]) begin
            dest_d = sh_dest_q;
            sim_d  = sh_sim_q;
          end
          if (dirty_q[1]) begin
            people_d = sh_ppl_q;
          end
          commit_d = |dirty_q;
          dirty_d  = 2'b00;
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      BLANK: begin
        if (at_top) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  // State and datapath registers; reset discards any pending shadow data
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      state_q       <= ACTIVE;
      div_q         <= 4'd0;
      sh_dest_q     <= '0;
      sh_sim_q      <= '0;
      sh_ppl_q      <= '0;
      dirty_q       <= 2'b00;
      dest_q        <= '0;
      sim_q         <= '0;
      people_q      <= '0;
      commit_q      <= 1'b0;
      elev_ack_q    <= 1'b0;
      ppl_ack_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      sh_dest_q     <= sh_dest_d;
      sh_sim_q      <= sh_sim_d;
      sh_ppl_q      <= sh_ppl_d;
      dirty_q       <= dirty_d;
      dest_q        <= dest_d;
      sim_q         <= sim_d;
      people_q      <= people_d;
      commit_q      <= commit_d;
      elev_ack_q    <= elev_ack_d;
      ppl_ack_q     <= ppl_ack_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign elev_ack    = elev_ack_q;
  assign ppl_ack     = ppl_ack_q;
  assign destination = dest_q;
  assign sim_state   = sim_q;
  assign people_data = people_q;
  assign commit      = commit_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign pending     = |dirty_q;

endmodule

// File: tb/tb_vga_frame_sync.sv
// Bench for vga_frame_sync. Two instances (commit every vblank, and every
// third vblank) share one stimulus stream; a frame-level reference model
// predicts acks, display values, commit pulses and frame counting.
module tb_vga_frame_sync;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  h;
  logic [9:0]  v;
  logic        elev_req;
  logic [7:0]  elev_destination;
  logic [1:0]  elev_sim_state;
  logic        ppl_req;
  logic [25:0] ppl_data;

  logic [1:0]       elev_ack_o;
  logic [1:0]       ppl_ack_o;
  logic [1:0][7:0]  dest_o;
  logic [1:0][1:0]  sim_o;
  logic [1:0][25:0] people_o;
  logic [1:0]       commit_o;
  logic [1:0]       frame_start_o;
  logic [1:0][7:0]  fc_o;
  logic [1:0]       pending_o;

  int compare_count = 0;
  int fail_count    = 0;

  // Reference model state
  bit          m_in_blank, m_commit_slot, m_ptr_ppl;
  bit          m_elev_ack, m_ppl_ack, m_frame_start;
  int          m_frame_count;
  logic [7:0]  m_sh_dest;
  logic [1:0]  m_sh_sim;
  logic [25:0] m_sh_ppl;
  bit          m_elev_new [2];
  bit          m_ppl_new [2];
  int          m_vblanks [2];
  int          m_every [2] = '{1, 3};
  logic [7:0]  m_dest [2];
  logic [1:0]  m_sim [2];
  logic [25:0] m_ppl [2];
  bit          m_commit [2];

  bit auto_req   = 1'b0;
  bit elev_drop  = 1'b0;
  bit ppl_drop   = 1'b0;
  bit seen_01    = 1'b0;
  bit commit_seen [2];

  always #5 pixel_clk = ~pixel_clk;

  vga_frame_sync #(.COMMIT_EVERY(1), .FCNT_W(8)) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .horiz_count(h), .vert_count(v),
    .elev_req(elev_req), .elev_destination(elev_destination),
    .elev_sim_state(elev_sim_state), .elev_ack(elev_ack_o[0]),
    .ppl_req(ppl_req), .ppl_data(ppl_data), .ppl_ack(ppl_ack_o[0]),
    .destination(dest_o[0]), .sim_state(sim_o[0]), .people_data(people_o[0]),
    .commit(commit_o[0]), .frame_start(frame_start_o[0]),
    .frame_count(fc_o[0]), .pending(pending_o[0])
  );

  vga_frame_sync #(.COMMIT_EVERY(3), .FCNT_W(8)) dut3 (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .horiz_count(h), .vert_count(v),
    .elev_req(elev_req), .elev_destination(elev_destination),
    .elev_sim_state(elev_sim_state), .elev_ack(elev_ack_o[1]),
    .ppl_req(ppl_req), .ppl_data(ppl_data), .ppl_ack(ppl_ack_o[1]),
    .destination(dest_o[1]), .sim_state(sim_o[1]), .people_data(people_o[1]),
    .commit(commit_o[1]), .frame_start(frame_start_o[1]),
    .frame_count(fc_o[1]), .pending(pending_o[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock using the inputs sampled at that edge
  task automatic model_update();
    bit e, p, ge, gp;
    if (!reset_n) begin
      m_in_blank = 0; m_commit_slot = 0; m_ptr_ppl = 0;
      m_elev_ack = 0; m_ppl_ack = 0; m_frame_start = 0; m_frame_count = 0;
      m_sh_dest = '0; m_sh_sim = '0; m_sh_ppl = '0;
      for (int k = 0; k < 2; k++) begin
        m_elev_new[k] = 0; m_ppl_new[k] = 0; m_vblanks[k] = 0;
        m_dest[k] = '0; m_sim[k] = '0; m_ppl[k] = '0; m_commit[k] = 0;
      end
      return;
    end
    e  = elev_req && !m_elev_ack && !m_commit_slot;
    p  = ppl_req && !m_ppl_ack && !m_commit_slot;
    ge = 0;
    gp = 0;
    if (e && p) begin
      if (m_ptr_ppl) gp = 1; else ge = 1;
      m_ptr_ppl = !m_ptr_ppl;
    end else begin
      ge = e;
      gp = p;
    end
    if (ge) begin
      m_sh_dest = elev_destination;
      m_sh_sim  = elev_sim_state;
      for (int k = 0; k < 2; k++) m_elev_new[k] = 1;
    end
    if (gp) begin
      m_sh_ppl = ppl_data;
      for (int k = 0; k < 2; k++) m_ppl_new[k] = 1;
    end
    m_elev_ack = ge;
    m_ppl_ack  = gp;
    for (int k = 0; k < 2; k++) begin
      m_commit[k] = 0;
      if (m_commit_slot) begin
        m_vblanks[k]++;
        if (m_vblanks[k] % m_every[k] == 0) begin
          m_commit[k] = m_elev_new[k] || m_ppl_new[k];
          if (m_elev_new[k]) begin
            m_dest[k] = m_sh_dest;
            m_sim[k]  = m_sh_sim;
          end
          if (m_ppl_new[k]) m_ppl[k] = m_sh_ppl;
          m_elev_new[k] = 0;
          m_ppl_new[k]  = 0;
        end
      end
    end
    m_frame_start = 0;
    if (m_commit_slot) begin
      m_commit_slot = 0;
      m_in_blank    = 1;
    end else if (!m_in_blank) begin
      if (v == 10'd480 && h == 10'd0) m_commit_slot = 1;
    end else if (v == 10'd0 && h == 10'd0) begin
      m_in_blank    = 0;
      m_frame_start = 1;
      m_frame_count = (m_frame_count + 1) % 256;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("elev_ack[%0d]", k), 32'(elev_ack_o[k]), 32'(m_elev_ack));
      checkOutput($sformatf("ppl_ack[%0d]", k), 32'(ppl_ack_o[k]), 32'(m_ppl_ack));
      checkOutput($sformatf("destination[%0d]", k), 32'(dest_o[k]), 32'(m_dest[k]));
      checkOutput($sformatf("sim_state[%0d]", k), 32'(sim_o[k]), 32'(m_sim[k]));
      checkOutput($sformatf("people_data[%0d]", k), 32'(people_o[k]), 32'(m_ppl[k]));
      checkOutput($sformatf("commit[%0d]", k), 32'(commit_o[k]), 32'(m_commit[k]));
      checkOutput($sformatf("frame_start[%0d]", k), 32'(frame_start_o[k]), 32'(m_frame_start));
      checkOutput($sformatf("frame_count[%0d]", k), 32'(fc_o[k]), 32'(m_frame_count));
      checkOutput($sformatf("pending[%0d]", k), 32'(pending_o[k]),
                  32'(m_elev_new[k] || m_ppl_new[k]));
    end
    if (dest_o[0] == 8'h01) seen_01 = 1'b1;
  endtask

  // Well-behaved requesters: hold req through the ack cycle, then drop or re-request
  task automatic drive_requesters();
    if (m_elev_ack) begin
      elev_drop = 1'b1;
    end else if (elev_drop) begin
      elev_drop = 1'b0;
      elev_req  = ($urandom_range(0, 3) == 0);
      elev_destination = 8'($urandom);
      elev_sim_state   = 2'($urandom);
    end else if (!elev_req && $urandom_range(0, 4) == 0) begin
      elev_req = 1'b1;
      elev_destination = 8'($urandom);
      elev_sim_state   = 2'($urandom);
    end
    if (m_ppl_ack) begin
      ppl_drop = 1'b1;
    end else if (ppl_drop) begin
      ppl_drop = 1'b0;
      ppl_req  = ($urandom_range(0, 3) == 0);
      ppl_data = 26'($urandom);
    end else if (!ppl_req && $urandom_range(0, 4) == 0) begin
      ppl_req  = 1'b1;
      ppl_data = 26'($urandom);
    end
  endtask

  // One pixel clock: inputs already set, sample #1 after the edge, then react
  task automatic applyStimulus();
    @(posedge pixel_clk);
    model_update();
    #1;
    compare_all();
    if (auto_req) drive_requesters();
  endtask

  // One visible region, vblank entry, commit cycle and a little blanking
  task automatic run_frame(input bit do_update);
    int mid;
    mid = int'($urandom_range(2, 8));
    if (do_update) begin
      h = 10'd50; v = 10'd200;
      elev_req = 1'b1;
      elev_destination = 8'($urandom);
      elev_sim_state   = 2'($urandom);
      applyStimulus();
      applyStimulus();
      elev_req = 1'b0;
      applyStimulus();
    end
    repeat (mid) begin
      h = 10'($urandom_range(0, 799));
      v = 10'($urandom_range(1, 479));
      applyStimulus();
    end
    h = 10'd0; v = 10'd480;
    applyStimulus();
    h = 10'd1;
    applyStimulus();
    for (int k = 0; k < 2; k++) commit_seen[k] = commit_o[k];
    repeat (2) begin
      h = 10'($urandom_range(0, 799));
      v = 10'($urandom_range(481, 1023));
      applyStimulus();
    end
  endtask

  initial begin
    reset_n = 1'b0; h = 10'd123; v = 10'd200;
    elev_req = 1'b0; elev_destination = '0; elev_sim_state = '0;
    ppl_req = 1'b0; ppl_data = '0;

    // Reset mid-frame
    applyStimulus();
    checkOutput("rst_destination", 32'(dest_o[0]), 32'h0);
    checkOutput("rst_pending", 32'(pending_o[0]), 32'h0);
    checkOutput("rst_frame_count", 32'(fc_o[0]), 32'h0);

    // Single elevator update, held until vblank entry
    reset_n = 1'b1; h = 10'd10; v = 10'd100;
    elev_req = 1'b1; elev_destination = 8'h24; elev_sim_state = 2'b10;
    applyStimulus();
    checkOutput("single_ack", 32'(elev_ack_o[0]), 32'h1);
    checkOutput("single_pending", 32'(pending_o[0]), 32'h1);
    checkOutput("single_dest_hidden", 32'(dest_o[0]), 32'h0);
    h = 10'd11;
    applyStimulus();
    checkOutput("single_ack_once", 32'(elev_ack_o[0]), 32'h0);
    elev_req = 1'b0; elev_destination = 8'hFF; v = 10'd300;
    repeat (3) applyStimulus();
    h = 10'd0; v = 10'd480;
    applyStimulus();
    checkOutput("single_dest_at_entry", 32'(dest_o[0]), 32'h0);
    h = 10'd1;
    applyStimulus();
    checkOutput("single_commit", 32'(commit_o[0]), 32'h1);
    checkOutput("single_dest", 32'(dest_o[0]), 32'h24);
    checkOutput("single_sim", 32'(sim_o[0]), 32'h2);
    checkOutput("single_commit_thr", 32'(commit_o[1]), 32'h0);
    h = 10'd5; v = 10'd490;
    applyStimulus();
    h = 10'd0; v = 10'd0;
    applyStimulus();
    checkOutput("frame_start", 32'(frame_start_o[0]), 32'h1);
    checkOutput("frame_count_1", 32'(fc_o[0]), 32'h1);
    h = 10'd1;
    applyStimulus();

    // Contention from reset: elevator first, then people; next collision people first
    reset_n = 1'b0;
    applyStimulus();
    reset_n = 1'b1; h = 10'd20; v = 10'd50;
    elev_req = 1'b1; elev_destination = 8'h11; elev_sim_state = 2'b01;
    ppl_req = 1'b1; ppl_data = 26'h1234567;
    applyStimulus();
    checkOutput("cont1_elev", 32'(elev_ack_o[0]), 32'h1);
    checkOutput("cont1_ppl", 32'(ppl_ack_o[0]), 32'h0);
    applyStimulus();
    checkOutput("cont2_elev", 32'(elev_ack_o[0]), 32'h0);
    checkOutput("cont2_ppl", 32'(ppl_ack_o[0]), 32'h1);
    elev_req = 1'b0;
    applyStimulus();
    ppl_req = 1'b0;
    applyStimulus();
    elev_req = 1'b1; ppl_req = 1'b1; elev_destination = 8'h22;
    applyStimulus();
    checkOutput("cont3_ppl_first", 32'(ppl_ack_o[0]), 32'h1);
    checkOutput("cont3_elev_wait", 32'(elev_ack_o[0]), 32'h0);
    applyStimulus();
    checkOutput("cont4_elev", 32'(elev_ack_o[0]), 32'h1);
    ppl_req = 1'b0;
    applyStimulus();
    elev_req = 1'b0;
    applyStimulus();

    // Overwrite within one frame: only the last value becomes visible
    seen_01 = 1'b0;
    elev_req = 1'b1; elev_destination = 8'h01;
    applyStimulus();
    applyStimulus();
    elev_req = 1'b0;
    applyStimulus();
    elev_req = 1'b1; elev_destination = 8'h80;
    applyStimulus();
    applyStimulus();
    elev_req = 1'b0;
    applyStimulus();
    h = 10'd0; v = 10'd480;
    applyStimulus();
    h = 10'd1;
    applyStimulus();
    checkOutput("overwrite_dest", 32'(dest_o[0]), 32'h80);
    checkOutput("overwrite_people", 32'(people_o[0]), 32'h1234567);
    checkOutput("overwrite_no_01", 32'(seen_01), 32'h0);
    h = 10'd0; v = 10'd0;
    applyStimulus();

    // Grant on the entry edge is committed; a request raised in COMMIT stalls one cycle
    h = 10'd7; v = 10'd100;
    applyStimulus();
    h = 10'd0; v = 10'd480; elev_req = 1'b1; elev_destination = 8'h5A;
    applyStimulus();
    checkOutput("entry_grant_ack", 32'(elev_ack_o[0]), 32'h1);
    ppl_req = 1'b1; ppl_data = 26'h0000003; h = 10'd1;
    applyStimulus();
    checkOutput("entry_grant_dest", 32'(dest_o[0]), 32'h5A);
    checkOutput("stall_no_ack", 32'(ppl_ack_o[0]), 32'h0);
    elev_req = 1'b0; h = 10'd2; v = 10'd481;
    applyStimulus();
    checkOutput("stall_late_ack", 32'(ppl_ack_o[0]), 32'h1);
    checkOutput("stall_people_hidden", 32'(people_o[0]), 32'h1234567);
    applyStimulus();
    ppl_req = 1'b0; v = 10'd700; h = 10'd0;
    repeat (2) applyStimulus();
    h = 10'd0; v = 10'd0;
    applyStimulus();
    h = 10'd9; v = 10'd9;
    applyStimulus();
    h = 10'd0; v = 10'd480;
    applyStimulus();
    h = 10'd1;
    applyStimulus();
    checkOutput("stall_people_next_frame", 32'(people_o[0]), 32'h3);
    h = 10'd0; v = 10'd0;
    applyStimulus();

    // Reset mid-frame discards pending data; no commit at the following vblank
    h = 10'd30; v = 10'd60; elev_req = 1'b1; elev_destination = 8'h77;
    applyStimulus();
    elev_req = 1'b0; reset_n = 1'b0; h = 10'd300; v = 10'd200;
    applyStimulus();
    checkOutput("rst2_pending", 32'(pending_o[0]), 32'h0);
    checkOutput("rst2_dest", 32'(dest_o[0]), 32'h0);
    reset_n = 1'b1; h = 10'd0; v = 10'd0;
    applyStimulus();
    checkOutput("rst2_no_frame_start", 32'(frame_start_o[0]), 32'h0);
    h = 10'd0; v = 10'd480;
    applyStimulus();
    h = 10'd1;
    applyStimulus();
    checkOutput("rst2_no_commit", 32'(commit_o[0]), 32'h0);
    checkOutput("rst2_dest_after", 32'(dest_o[0]), 32'h0);

    // Throttle and frame counter wrap, directed updates then random traffic
    reset_n = 1'b0; h = 10'd300; v = 10'd300;
    applyStimulus();
    reset_n = 1'b1;
    for (int f = 1; f <= 257; f++) begin
      auto_req = (f > 10);
      run_frame(f <= 10);
      if (f <= 10) begin
        checkOutput($sformatf("thr_commit3_f%0d", f), 32'(commit_seen[1]), 32'(f % 3 == 0));
        checkOutput($sformatf("thr_commit1_f%0d", f), 32'(commit_seen[0]), 32'h1);
      end
      h = 10'd0; v = 10'd0;
      applyStimulus();
      if (f == 255) checkOutput("fc_255", 32'(fc_o[0]), 32'd255);
      if (f == 256) checkOutput("fc_wrap", 32'(fc_o[0]), 32'd0);
    end
    auto_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
